// File: rtl/mips_arb_pkg.sv
// Shared types and constants for the MIPS Avalon-MM arbiter.
package mips_arb_pkg;

    localparam int MAX_MASTERS = 8;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Width of a master index, with the master count clamped to the supported range
    function automatic int arb_idx_w(input int n);
        int n_c;
        n_c = (n < 2) ? 2 : ((n > MAX_MASTERS) ? MAX_MASTERS : n);
        return $clog2(n_c);
    endfunction

endpackage

// File: rtl/mips_arb_picker.sv
// Combinational winner selection for the MIPS Avalon-MM arbiter.
// Default: round-robin starting just above last_grant.
// MIPS_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
// and the last_grant input is not present.
module mips_arb_picker #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] req,
`ifndef MIPS_ARB_FIXED_PRIO_EN
    input  logic [IDX_W-1:0]       last_grant,
`endif
    output logic [IDX_W-1:0]       winner,
    output logic                   valid
);

    logic [NUM_MASTERS-1:0] sh_s;

`ifdef MIPS_ARB_FIXED_PRIO_EN

    // Scan from the top down so the lowest requesting index is the last one written
    always_comb begin
        winner = {IDX_W{1'b0}};
        sh_s   = {NUM_MASTERS{1'b0}};
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            sh_s   = req >> i;
            winner = sh_s[0] ? IDX_W'(i) : winner;
        end
        valid = |req;
    end

`else

    int   idx_s;
    logic hit_s;

    // Walk upward from last_grant+1 with wrap; the first requester found wins
    always_comb begin
        winner = {IDX_W{1'b0}};
        valid  = 1'b0;
        idx_s  = 0;
        sh_s   = {NUM_MASTERS{1'b0}};
        hit_s  = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx_s  = (int'(last_grant) + k) % NUM_MASTERS;
            sh_s   = req >> idx_s;
            hit_s  = sh_s[0] & ~valid;
            winner = hit_s ? IDX_W'(idx_s) : winner;
            valid  = valid | hit_s;
        end
    end

`endif

endmodule

// File: rtl/mips_avalon_arbiter.sv
// Avalon-MM arbiter sharing one slave between NUM_MASTERS masters.
// A grant is taken in IDLE, held in BUSY until the slave completes the
// transfer (or the master withdraws), and never pre-empted.
// Build option: MIPS_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
// instead of the default round-robin.
module mips_avalon_arbiter
    import mips_arb_pkg::*;
#(
    parameter int  NUM_MASTERS = 2,
    parameter int  ADDR_W      = 32,
    parameter int  DATA_W      = 32,
    localparam int BE_W        = DATA_W / 8,
    localparam int IDX_W       = arb_idx_w(NUM_MASTERS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [DATA_W-1:0]             m_readdata,
    output logic [ADDR_W-1:0]             s_address,
    output logic [BE_W-1:0]               s_byteenable,
    output logic                          s_read,
    output logic                          s_write,
    output logic [DATA_W-1:0]             s_writedata,
    input  logic                          s_waitrequest,
    input  logic [DATA_W-1:0]             s_readdata,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          busy
);

    arb_state_t             state_r;
    logic [IDX_W-1:0]       grant_idx_r;
    logic [ADDR_W-1:0]      hold_addr_r;
    logic [BE_W-1:0]        hold_be_r;
    logic [DATA_W-1:0]      hold_wdata_r;

    logic [NUM_MASTERS-1:0] req_s;
    logic [IDX_W-1:0]       pick_winner_s;
    logic                   pick_valid_s;
    logic                   busy_s;
    logic                   gnt_read_s;
    logic                   gnt_write_s;
    logic                   gnt_req_s;
    logic [ADDR_W-1:0]      gnt_addr_s;
    logic [BE_W-1:0]        gnt_be_s;
    logic [DATA_W-1:0]      gnt_wdata_s;

    assign req_s  = m_read | m_write;
    assign busy_s = (state_r == ARB_BUSY);

`ifdef MIPS_ARB_FIXED_PRIO_EN
    mips_arb_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req        (req_s),
        .winner     (pick_winner_s),
        .valid      (pick_valid_s)
    );
`else
    logic [IDX_W-1:0] last_grant_r;

    mips_arb_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req        (req_s),
        .last_grant (last_grant_r),
        .winner     (pick_winner_s),
        .valid      (pick_valid_s)
    );
`endif

    assign gnt_read_s  = m_read[grant_idx_r];
    assign gnt_write_s = m_write[grant_idx_r];
    assign gnt_req_s   = gnt_read_s | gnt_write_s;

    // Select the granted master's address, byte enables and write data
    always_comb begin
        gnt_addr_s  = {ADDR_W{1'b0}};
        gnt_be_s    = {BE_W{1'b0}};
        gnt_wdata_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_MASTERS; i++) begin
            gnt_addr_s  = (grant_idx_r == IDX_W'(i)) ? m_address[i*ADDR_W +: ADDR_W]   : gnt_addr_s;
            gnt_be_s    = (grant_idx_r == IDX_W'(i)) ? m_byteenable[i*BE_W +: BE_W]    : gnt_be_s;
            gnt_wdata_s = (grant_idx_r == IDX_W'(i)) ? m_writedata[i*DATA_W +: DATA_W] : gnt_wdata_s;
        end
    end

    // Arbitration FSM: grant in IDLE, hold through BUSY, release on completion or withdrawal
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ARB_IDLE;
            grant_idx_r  <= {IDX_W{1'b0}};
            hold_addr_r  <= {ADDR_W{1'b0}};
            hold_be_r    <= {BE_W{1'b0}};
            hold_wdata_r <= {DATA_W{1'b0}};
`ifndef MIPS_ARB_FIXED_PRIO_EN
            last_grant_r <= IDX_W'(NUM_MASTERS - 1);
`endif
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (pick_valid_s) begin
                        grant_idx_r <= pick_winner_s;
                        state_r     <= ARB_BUSY;
                    end else begin
                        state_r     <= ARB_IDLE;
                    end
                end
                ARB_BUSY: begin
                    // Remember what was on the bus so IDLE keeps presenting it
                    hold_addr_r  <= gnt_addr_s;
                    hold_be_r    <= gnt_be_s;
                    hold_wdata_r <= gnt_wdata_s;
                    if (!gnt_req_s) begin
                        // Master withdrew mid-grant: drop it without touching the rotation
                        state_r <= ARB_IDLE;
                    end else if (!s_waitrequest) begin
`ifndef MIPS_ARB_FIXED_PRIO_EN
                        last_grant_r <= grant_idx_r;
`endif
                        state_r <= ARB_IDLE;
                    end else begin
                        state_r <= ARB_BUSY;
                    end
                end
                default: begin
                    state_r <= ARB_IDLE;
                end
            endcase
        end
    end

    // Stall every master except the granted one, which sees the slave's stall
    always_comb begin
        m_waitrequest = {NUM_MASTERS{1'b1}};
        if (busy_s) begin
            m_waitrequest[grant_idx_r] = s_waitrequest;
        end else begin
            m_waitrequest = {NUM_MASTERS{1'b1}};
        end
    end

    // Commands are gated by BUSY so a withdrawn request never reaches the slave;
    // write wins when a master asserts both.
    assign s_read       = busy_s & gnt_read_s & ~gnt_write_s;
    assign s_write      = busy_s & gnt_write_s;
    assign s_address    = busy_s ? gnt_addr_s  : hold_addr_r;
    assign s_byteenable = busy_s ? gnt_be_s    : hold_be_r;
    assign s_writedata  = busy_s ? gnt_wdata_s : hold_wdata_r;
    assign m_readdata   = s_readdata;
    assign grant_idx    = grant_idx_r;
    assign busy         = busy_s;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Directed bench for mips_avalon_arbiter (2 masters, 32-bit address/data).
// Expected slave transfers are queued as stimulus is driven and checked by a
// monitor on the falling edge of each completing BUSY cycle.
module tb_mips_avalon_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NM*AW-1:0] m_address;
    logic [NM*BW-1:0] m_byteenable;
    logic [NM-1:0]   m_read;
    logic [NM-1:0]   m_write;
    logic [NM*DW-1:0] m_writedata;
    logic [NM-1:0]   m_waitrequest;
    logic [DW-1:0]   m_readdata;
    logic [AW-1:0]   s_address;
    logic [BW-1:0]   s_byteenable;
    logic            s_read;
    logic            s_write;
    logic [DW-1:0]   s_writedata;
    logic            s_waitrequest;
    logic [DW-1:0]   s_readdata;
    logic [0:0]      grant_idx;
    logic            busy;

    typedef struct {
        int          idx;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } xfer_t;

    xfer_t sb_q[$];
    xfer_t e_v;
    int    checks = 0;
    int    errors = 0;
    int    exp_idx;
    logic [31:0] d_v;

    mips_avalon_arbiter #(
        .NUM_MASTERS (NM),
        .ADDR_W      (AW),
        .DATA_W      (DW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .m_address     (m_address),
        .m_byteenable  (m_byteenable),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_waitrequest (m_waitrequest),
        .m_readdata    (m_readdata),
        .s_address     (s_address),
        .s_byteenable  (s_byteenable),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_waitrequest (s_waitrequest),
        .s_readdata    (s_readdata),
        .grant_idx     (grant_idx),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be);
        xfer_t e;
        e.idx  = idx;
        e.wr   = wr;
        e.addr = addr;
        e.data = data;
        e.be   = be;
        sb_q.push_back(e);
    endtask

    // Compare every completing slave transfer against the oldest queued expectation
    always @(negedge clk) begin
        if (reset_n && busy && (s_read || s_write) && !s_waitrequest) begin
            chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e_v = sb_q.pop_front();
                chk("mon_grant", 32'(grant_idx), 32'(e_v.idx));
                chk("mon_write", 32'(s_write), 32'(e_v.wr));
                chk("mon_read", 32'(s_read), 32'(!e_v.wr));
                chk("mon_addr", s_address, e_v.addr);
                chk("mon_be", 32'(s_byteenable), 32'(e_v.be));
                chk("mon_data", e_v.wr ? s_writedata : m_readdata, e_v.data);
                chk("mon_mwait", 32'((m_waitrequest >> e_v.idx) & 2'b01), 32'd0);
            end
        end
    end

    initial begin
        // ---- reset with both masters requesting ----
        reset_n       = 1'b0;
        m_read        = 2'b11;
        m_write       = 2'b00;
        m_address     = {A1, A0};
        m_byteenable  = 8'hFF;
        m_writedata   = 64'h0;
        s_waitrequest = 1'b0;
        s_readdata    = 32'h0;
        repeat (3) tick();
        chk("rst_mwait", 32'(m_waitrequest), 32'd3);
        chk("rst_sread", 32'(s_read), 32'd0);
        chk("rst_swrite", 32'(s_write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_idx), 32'd0);
        chk("rst_addr", s_address, 32'd0);
        chk("rst_be", 32'(s_byteenable), 32'd0);
        chk("rst_wdata", s_writedata, 32'd0);

        push(0, 1'b0, A0, 32'h1111_0000, 4'hF);
        s_readdata = 32'h1111_0000;
        reset_n    = 1'b1;
        tick();
        chk("first_grant", 32'(grant_idx), 32'd0);
        chk("first_busy", 32'(busy), 32'd1);
        chk("first_sread", 32'(s_read), 32'd1);
        chk("first_mwait", 32'(m_waitrequest), 32'd2);
        tick();
        m_read = 2'b10;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_sread", 32'(s_read), 32'd0);
        chk("idle_hold_addr", s_address, A0);
        push(1, 1'b0, A1, 32'h2222_0000, 4'hF);
        s_readdata = 32'h2222_0000;
        tick();
        chk("second_grant", 32'(grant_idx), 32'd1);
        chk("second_mwait", 32'(m_waitrequest), 32'd1);
        tick();
        m_read = 2'b00;

        // ---- single write from master 1 (read also asserted: write wins) ----
        m_address    = {32'h0000_0010, A0};
        m_writedata  = {32'hDEAD_BEEF, 32'h0};
        m_byteenable = {4'hF, 4'h3};
        m_write      = 2'b10;
        m_read       = 2'b10;
        push(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        tick();
        chk("wr_grant", 32'(grant_idx), 32'd1);
        chk("wr_swrite", 32'(s_write), 32'd1);
        chk("wr_sread", 32'(s_read), 32'd0);
        chk("wr_mwait", 32'(m_waitrequest), 32'd1);
        tick();
        chk("wr_done_swrite", 32'(s_write), 32'd0);
        chk("wr_done_busy", 32'(busy), 32'd0);
        chk("wr_hold_wdata", s_writedata, 32'hDEAD_BEEF);
        m_write = 2'b00;
        m_read  = 2'b00;

        // ---- both masters reading continuously: 8 transfers ----
        m_address    = {A1, A0};
        m_byteenable = 8'hFF;
        m_read       = 2'b11;
        for (int i = 0; i < 8; i++) begin
`ifdef MIPS_ARB_FIXED_PRIO_EN
            exp_idx = 0;
`else
            exp_idx = i % 2;
`endif
            d_v = 32'hA000_0000 + 32'(i);
            push(exp_idx, 1'b0, (exp_idx == 1) ? A1 : A0, d_v, 4'hF);
            s_readdata = d_v;
            tick();
            chk("rr_grant", 32'(grant_idx), 32'(exp_idx));
            tick();
        end
        m_read = 2'b00;
        tick();

        // ---- slave stall of 5 cycles on a master 0 read ----
        m_read        = 2'b11;
        s_waitrequest = 1'b1;
        push(0, 1'b0, A0, 32'h1234_5678, 4'hF);
        s_readdata = 32'h1234_5678;
        tick();
        chk("stall_grant", 32'(grant_idx), 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_mwait", 32'(m_waitrequest), 32'd3);
            tick();
        end
        s_waitrequest = 1'b0;
        #1;
        chk("stall_last_busy", 32'(busy), 32'd1);
        chk("stall_last_mwait", 32'(m_waitrequest), 32'd2);
        tick();
        m_read = 2'b10;
        chk("stall_done_busy", 32'(busy), 32'd0);
        chk("stall_done_mwait", 32'(m_waitrequest), 32'd3);
        push(1, 1'b0, A1, 32'h55AA_0001, 4'hF);
        s_readdata = 32'h55AA_0001;
        tick();
        chk("stall_next_grant", 32'(grant_idx), 32'd1);
        tick();
        m_read = 2'b00;

        // ---- protocol violation: master 0 withdraws during BUSY ----
        m_read = 2'b01;
        tick();
        chk("viol_grant", 32'(grant_idx), 32'd0);
        m_read = 2'b00;
        #1;
        chk("viol_sread", 32'(s_read), 32'd0);
        chk("viol_swrite", 32'(s_write), 32'd0);
        tick();
        chk("viol_idle", 32'(busy), 32'd0);
        m_read = 2'b11;
        push(0, 1'b0, A0, 32'h0BAD_0001, 4'hF);
        s_readdata = 32'h0BAD_0001;
        tick();
        chk("viol_rr_order", 32'(grant_idx), 32'd0);
        tick();
        m_read = 2'b10;
        push(1, 1'b0, A1, 32'h0BAD_0002, 4'hF);
        s_readdata = 32'h0BAD_0002;
        tick();
        chk("viol_next_grant", 32'(grant_idx), 32'd1);
        tick();
        m_read = 2'b00;

        // ---- reset during a stalled master 0 write, master 1 read pending ----
        m_writedata   = {32'h0, 32'hCAFE_F00D};
        m_write       = 2'b01;
        m_read        = 2'b10;
        s_waitrequest = 1'b1;
        tick();
        chk("mrst_grant", 32'(grant_idx), 32'd0);
        chk("mrst_swrite_before", 32'(s_write), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mrst_swrite", 32'(s_write), 32'd0);
        chk("mrst_sread", 32'(s_read), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_mwait", 32'(m_waitrequest), 32'd3);
        chk("mrst_wdata", s_writedata, 32'd0);
        m_write = 2'b00;
        tick();
        reset_n       = 1'b1;
        s_waitrequest = 1'b0;
        push(1, 1'b0, A1, 32'h7777_0001, 4'hF);
        s_readdata = 32'h7777_0001;
        tick();
        chk("mrst_after_grant", 32'(grant_idx), 32'd1);
        chk("mrst_after_busy", 32'(busy), 32'd1);
        tick();
        m_read = 2'b00;
        chk("mrst_after_idle", 32'(busy), 32'd0);

        repeat (2) tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
